// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared constants, types and helpers for the HD44780-compatible
// LCD responder.
//   * Address counter (AC) line bases and line ends for the 2-line layout
//   * SPACE fill character
//   * FSM state encodings for the responder
//   * AC operation type and instruction class decode
package lcd_pkg;

    // DDRAM address map of a 2x40 HD44780. Only the first 16 columns of each
    // line are shadowed.
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;

    localparam logic [7:0] SPACE = 8'h20;

    localparam int DDRAM_BYTES = 32;

    // Responder FSM states
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_EN_HIGH     = 3'd1;
    localparam logic [2:0] ST_EXEC        = 3'd2;
    localparam logic [2:0] ST_CLEAR_SWEEP = 3'd3;
    localparam logic [2:0] ST_BUSY        = 3'd4;

    typedef enum logic [2:0] {
        AC_NOP,
        AC_SET,
        AC_INC,
        AC_DEC,
        AC_HOME
    } ac_op_t;

    // Instruction class, selected by the highest set bit of the data byte.
    typedef enum logic [3:0] {
        I_NOP,
        I_CLEAR,
        I_HOME,
        I_ENTRY,
        I_DISPLAY,
        I_SHIFT,
        I_FUNC,
        I_CGRAM,
        I_DDRAM
    } instr_t;

    function automatic instr_t decode_instr(input logic [7:0] d);
        instr_t r;
        casez (d)
            8'b1???????: r = I_DDRAM;
            8'b01??????: r = I_CGRAM;
            8'b001?????: r = I_FUNC;
            8'b0001????: r = I_SHIFT;
            8'b00001???: r = I_DISPLAY;
            8'b000001??: r = I_ENTRY;
            8'b0000001?: r = I_HOME;
            8'b00000001: r = I_CLEAR;
            default:     r = I_NOP;
        endcase
        return r;
    endfunction

    // True when an address lies inside one of the two legal AC windows.
    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
    endfunction

endpackage

// File: rtl/lcd_addr_counter.sv
// lcd_addr_counter -- HD44780 address counter with 2-line wrap.
//   clk, rst   : clock, asynchronous active-high reset (AC -> 0x00)
//   op         : AC operation (set/inc/dec/home/nop)
//   set_value  : new AC value for AC_SET, clamped to 0x00 when outside
//                0x00-0x27 / 0x40-0x67
//   ac         : current address counter
//   mapped     : AC points at a shadowed DDRAM position
//   index      : shadow index (0-15 line 1, 16-31 line 2), valid when mapped
module lcd_addr_counter
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  ac_op_t     op,
    input  logic [6:0] set_value,
    output logic [6:0] ac,
    output logic       mapped,
    output logic [4:0] index
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac <= LINE1_BASE;
        end else begin
            case (op)
                AC_SET:  ac <= ac_valid(set_value) ? set_value : LINE1_BASE;
                AC_HOME: ac <= LINE1_BASE;
                AC_INC: begin
                    if (ac == LINE1_END)      ac <= LINE2_BASE;
                    else if (ac == LINE2_END) ac <= LINE1_BASE;
                    else                      ac <= ac + 7'd1;
                end
                AC_DEC: begin
                    if (ac == LINE1_BASE)      ac <= LINE2_END;
                    else if (ac == LINE2_BASE) ac <= LINE1_END;
                    else                       ac <= ac - 7'd1;
                end
                default: ;
            endcase
        end
    end

    // AC never leaves 0x00-0x27 / 0x40-0x67, so bits [5:4] == 0 alone
    // identifies columns 0-15 of either line; bit 6 selects the line.
    assign mapped = (ac[5:4] == 2'b00);
    assign index  = {ac[6], ac[3:0]};

endmodule

// File: rtl/lcd_responder.sv
// lcd_responder -- HD44780-compatible responder for the 2x16 LCD bus.
// Executes instruction/data writes into a 32-byte DDRAM shadow and answers
// busy-flag and data reads.
//   clk, rst      : clock, asynchronous active-high reset
//   lcd_en        : enable strobe (synchronized, command runs on its fall)
//   lcd_rs        : register select (0 instruction, 1 data)
//   lcd_rw        : 0 write, 1 read
//   lcd_data_in   : bus data from the driver
//   lcd_data_out  : read data, latched when a read strobe is first seen
//   lcd_data_oe   : read data valid / bus drive enable
//   busy          : busy flag
//   ddram         : shadow contents, byte k = position k
//   violation     : sticky, a write ended while busy
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 37,
    parameter int CLEAR_CYCLES = 1520
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_en,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [7:0]   lcd_data_in,
    output logic [7:0]   lcd_data_out,
    output logic         lcd_data_oe,
    output logic         busy,
    output logic [255:0] ddram,
    output logic         violation
);

    localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             en_s1, en_s2, en_s3;
    logic             en_fall;
    logic             rs_q, rw_q;
    logic [7:0]       data_q;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       sweep_idx;
    logic             id_q;
    logic             cg_mode;
    logic [7:0]       mem [DDRAM_BYTES];
    logic [7:0]       read_byte;
    instr_t           instr;

    ac_op_t     ac_op;
    logic [6:0] ac;
    logic       ac_mapped;
    logic [4:0] ac_index;

    lcd_addr_counter u_ac (
        .clk       (clk),
        .rst       (rst),
        .op        (ac_op),
        .set_value (data_q[6:0]),
        .ac        (ac),
        .mapped    (ac_mapped),
        .index     (ac_index)
    );

    // EN synchronizer; en_s3 only serves falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1 <= 1'b0;
            en_s2 <= 1'b0;
            en_s3 <= 1'b0;
        end else begin
            en_s1 <= lcd_en;
            en_s2 <= en_s1;
            en_s3 <= en_s2;
        end
    end

    assign en_fall = en_s3 & ~en_s2;

    // Bus fields follow the bus while EN is high, so the last values seen
    // before the fall are what the command executes with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            data_q <= 8'h00;
        end else if (en_s2) begin
            rs_q   <= lcd_rs;
            rw_q   <= lcd_rw;
            data_q <= lcd_data_in;
        end
    end

    assign instr     = decode_instr(data_q);
    assign read_byte = (!cg_mode && ac_mapped) ? mem[ac_index] : SPACE;

    // AC operation for the command being executed.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ac_op = AC_NOP;
        if (state == ST_EXEC) begin
            if (!rs_q && !rw_q) begin
                case (instr)
                    I_CLEAR, I_HOME: ac_op = AC_HOME;
                    I_SHIFT:         if (!data_q[3]) ac_op = data_q[2] ? AC_INC : AC_DEC;
                    I_DDRAM:         ac_op = AC_SET;
                    default:         ac_op = AC_NOP;
                endcase
            end else if (rs_q && !cg_mode) begin
                // data read or write: step per I/D
                ac_op = id_q ? AC_INC : AC_DEC;
            end
        end
    end

    // Main FSM, DDRAM shadow and busy timing. Display control, function set
    // and the entry-mode shift flag have no visible effect in this model, so
    // they are accepted and timed like any command but not stored.
    // NOTE: the 32-byte shadow is plain flops and must read back as spaces
    // straight out of reset, so it is reset along with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            sweep_idx <= 5'd0;
            id_q      <= 1'b1;
            cg_mode   <= 1'b0;
            violation <= 1'b0;
            for (int k = 0; k < DDRAM_BYTES; k++) mem[k] <= SPACE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_s2) state <= ST_EN_HIGH;
                end
                ST_EN_HIGH: begin
                    if (!en_s2) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_BUSY;
                    busy  <= 1'b1;
                    cnt   <= CNT_W'(BUSY_CYCLES - 1);
                    if (!rs_q && rw_q) begin
                        // busy-flag read has no side effects and no busy time
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (rs_q) begin
                        if (!rw_q && !cg_mode && ac_mapped) mem[ac_index] <= data_q;
                    end else begin
                        case (instr)
                            I_CLEAR: begin
                                state     <= ST_CLEAR_SWEEP;
                                cnt       <= CNT_W'(CLEAR_CYCLES - 1);
                                sweep_idx <= 5'd0;
                                id_q      <= 1'b1;
                            end
                            I_HOME:  cnt     <= CNT_W'(CLEAR_CYCLES - 1);
                            I_ENTRY: id_q    <= data_q[1];
                            I_CGRAM: cg_mode <= 1'b1;
                            I_DDRAM: cg_mode <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR_SWEEP: begin
                    // one byte per cycle; the busy count keeps running so the
                    // sweep is part of the clear busy time
                    mem[sweep_idx] <= SPACE;
                    sweep_idx      <= sweep_idx + 5'd1;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (sweep_idx == 5'd31) state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A write strobe ending while busy is dropped and flagged; reads
            // during busy are legal and never step AC.
            if ((state == ST_CLEAR_SWEEP || state == ST_BUSY) && en_fall && !rw_q)
                violation <= 1'b1;
        end
    end

    // Read port: OE tracks the synchronized strobe with a one-cycle lag, and
    // the data is captured once when the strobe is first seen so it holds
    // steady for the whole OE window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= 8'h00;
        end else begin
            lcd_data_oe <= en_s1 & lcd_rw;
            if (en_s1 && !en_s2 && lcd_rw)
                lcd_data_out <= lcd_rs ? read_byte : {busy, ac};
        end
    end

    always_comb begin
        for (int k = 0; k < DDRAM_BYTES; k++) ddram[8*k +: 8] = mem[k];
    end

endmodule

// File: tb/tb_lcd_responder.sv
module tb_lcd_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data_in;
    logic [7:0]   lcd_data_out;
    logic         lcd_data_oe;
    logic         busy;
    logic [255:0] ddram;
    logic         violation;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   rd_q [$];
    logic [255:0] exp_ddram;
    logic         oe_d = 1'b0;

    lcd_responder #(
        .BUSY_CYCLES  (37),
        .CLEAR_CYCLES (1520)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_en       (lcd_en),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .busy         (busy),
        .ddram        (ddram),
        .violation    (violation)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every read pushes its expected byte; the byte is popped and
    // compared when the DUT raises OE.
    always @(negedge clk) begin
        if (lcd_data_oe && !oe_d) begin
            check("rd_pending", rd_q.size() != 0, 1'b1);
            if (rd_q.size() != 0) check("rd_data", lcd_data_out, rd_q.pop_front());
        end
        oe_d = lcd_data_oe;
    end

    task automatic set_exp(input int k, input logic [7:0] v);
        exp_ddram[8*k +: 8] = v;
    endtask

    task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs      = rs;
        lcd_rw      = rw;
        lcd_data_in = d;
        lcd_en      = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic op(input logic rs, input logic rw, input logic [7:0] d);
        bus_op(rs, rw, d);
        wait_idle();
    endtask

    task automatic busy_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        op(1'b0, 1'b1, 8'h00);
    endtask

    task automatic data_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        op(1'b1, 1'b1, 8'h00);
    endtask

    // Busy read with OE edge timing checked against the EN edges.
    task automatic busy_read_timed(input logic [7:0] exp);
        rd_q.push_back(exp);
        @(negedge clk);
        lcd_rs = 1'b0;
        lcd_rw = 1'b1;
        lcd_en = 1'b1;
        @(negedge clk);
        check("oe_rise_early", lcd_data_oe, 1'b0);
        @(negedge clk);
        check("oe_rise", lcd_data_oe, 1'b1);
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
        check("oe_fall_early", lcd_data_oe, 1'b1);
        @(negedge clk);
        check("oe_fall", lcd_data_oe, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b1;
        lcd_en      = 1'b0;
        lcd_rs      = 1'b0;
        lcd_rw      = 1'b0;
        lcd_data_in = 8'h00;
        exp_ddram   = {32{8'h20}};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ddram", ddram, exp_ddram);
        check("rst_busy", busy, 1'b0);
        check("rst_oe", lcd_data_oe, 1'b0);
        check("rst_dout", lcd_data_out, 8'h00);
        check("rst_viol", violation, 1'b0);
        rst = 1'b0;
        busy_read(8'h00);

        // clear: busy for exactly CLEAR_CYCLES
        bus_op(1'b0, 1'b0, 8'h01);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("clear_cycles", n, 1520);
        check("clear_ddram", ddram, exp_ddram);

        // entry increment, write 'A','B'
        op(1'b0, 1'b0, 8'h06);
        op(1'b1, 1'b0, 8'h41);
        op(1'b1, 1'b0, 8'h42);
        set_exp(0, 8'h41);
        set_exp(1, 8'h42);
        check("ddram_ab", ddram, exp_ddram);
        busy_read(8'h02);

        // line-1 end wrap: 0x27 unmapped, AC wraps to 0x40
        op(1'b0, 1'b0, 8'hA7);
        op(1'b1, 1'b0, 8'h58);
        op(1'b1, 1'b0, 8'h59);
        set_exp(16, 8'h59);
        check("ddram_wrap", ddram, exp_ddram);
        busy_read(8'h41);

        // decrement from 0x00 wraps to 0x67; read while busy shows busy bit
        op(1'b0, 1'b0, 8'h80);
        op(1'b0, 1'b0, 8'h04);
        bus_op(1'b1, 1'b0, 8'h5A);
        set_exp(0, 8'h5A);
        check("ddram_z", ddram, exp_ddram);
        check("busy_rise", busy, 1'b1);
        busy_read_timed(8'hE7);
        check("viol_after_read", violation, 1'b0);
        wait_idle();
        busy_read(8'h67);

        // write during busy is dropped and flagged
        bus_op(1'b0, 1'b0, 8'h85);
        bus_op(1'b1, 1'b0, 8'h51);
        check("viol_set", violation, 1'b1);
        wait_idle();
        check("ddram_viol", ddram, exp_ddram);
        busy_read(8'h05);
        op(1'b0, 1'b0, 8'h06);
        check("viol_sticky", violation, 1'b1);

        // clear restores spaces, AC 0 and I/D=1
        op(1'b0, 1'b0, 8'h01);
        exp_ddram = {32{8'h20}};
        check("clear2_ddram", ddram, exp_ddram);
        busy_read(8'h00);
        op(1'b1, 1'b0, 8'h43);
        set_exp(0, 8'h43);

        // CGRAM mode discards data writes
        op(1'b0, 1'b0, 8'h40);
        op(1'b1, 1'b0, 8'h55);
        op(1'b0, 1'b0, 8'hC5);
        data_read(8'h20);
        busy_read(8'h46);
        check("ddram_cg", ddram, exp_ddram);
        op(1'b0, 1'b0, 8'h80);
        data_read(8'h43);
        busy_read(8'h01);

        // set-address clamp and cursor shift
        op(1'b0, 1'b0, 8'hB0);
        busy_read(8'h00);
        op(1'b0, 1'b0, 8'h14);
        busy_read(8'h01);
        op(1'b0, 1'b0, 8'h10);
        op(1'b0, 1'b0, 8'h10);
        busy_read(8'h67);
        op(1'b0, 1'b0, 8'h18);
        busy_read(8'h67);

        // reset in the middle of a home busy period
        op(1'b0, 1'b0, 8'h80);
        op(1'b1, 1'b0, 8'h4D);
        check("ddram_m", ddram[7:0], 8'h4D);
        bus_op(1'b0, 1'b0, 8'h02);
        repeat (10) @(negedge clk);
        check("home_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_ddram", ddram, {32{8'h20}});
        check("midrst_viol", violation, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        busy_read(8'h00);

        repeat (4) @(negedge clk);
        check("sb_drain", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
